// File: rtl/mult_tr_pkg.sv
// Shared types and latency helpers for the time-redundant sequential multiplier.
// Latency helpers count edges from the accept edge to the first out_valid cycle.
package mult_tr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    PASS2 = 3'd2,
    CHECK = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int PW        = 2 * DEF_WIDTH;

  function automatic int lat_cycles(input int width, input int redundant);
    return (redundant != 0) ? (2 * width + 2) : (width + 2);
  endfunction

  function automatic int retry_cycles(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// One shift-add multiply pass: start loads operands and folds in bit 0.
// Result is valid with the one-cycle done pulse, WIDTH cycles after start.
module mult_shift_add_core #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mc;
  logic [WIDTH-1:0] mr;
  logic [CW-1:0]    cnt;
  logic             run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      mc   <= '0;
      mr   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // the load edge doubles as the bit-0 step so a pass spans exactly WIDTH edges
        acc <= mplier[0] ? {{WIDTH{1'b0}}, mcand} : '0;
        mc  <= {{(WIDTH-1){1'b0}}, mcand, 1'b0};
        mr  <= {1'b0, mplier[WIDTH-1:1]};
        cnt <= CW'(1);
        run <= 1'b1;
      end else if (run) begin
        if (mr[0]) acc <= acc + mc;
        mc  <= mc << 1;
        mr  <= mr >> 1;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/mult_seq_tr.sv
// Time-redundant WIDTHxWIDTH multiplier: two swapped-operand passes, compare, retry.
// Holds out_valid/product/err until out_ready; in_ready only in IDLE, so no overlap.
module mult_seq_tr
  import mult_tr_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int REDUNDANT = 1,
  parameter int RETRY_MAX = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 fi_arm,
  input  logic                 fi_persist,
  input  logic [2*WIDTH-1:0]   fi_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 err,
  output logic                 busy,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int MW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             arm_q, pers_q;
  logic [MW-1:0]    mask_q;
  logic [2:0]       attempt;
  logic [MW-1:0]    r1, r2;
  logic             kick;

  logic             core_start, core_done;
  logic [WIDTH-1:0] core_mcand, core_mplier;
  logic [MW-1:0]    core_res;
  logic             use_mask, mismatch, can_retry;

  assign use_mask  = pers_q | (arm_q & (attempt == 3'd0));
  assign mismatch  = (REDUNDANT != 0) && (r1 != r2);
  assign can_retry = (attempt < 3'(RETRY_MAX));

  // pass 2 runs with the operands swapped; every other start is a pass 1
  always_comb begin
    core_start  = kick;
    core_mcand  = a_q;
    core_mplier = b_q;
    if (state == PASS1 && core_done && REDUNDANT != 0) begin
      core_start  = 1'b1;
      core_mcand  = b_q;
      core_mplier = a_q;
    end else if (state == CHECK && mismatch && can_retry) begin
      core_start  = 1'b1;
    end
  end

  mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .mcand  (core_mcand),
    .mplier (core_mplier),
    .done   (core_done),
    .result (core_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      arm_q     <= 1'b0;
      pers_q    <= 1'b0;
      mask_q    <= '0;
      attempt   <= '0;
      r1        <= '0;
      r2        <= '0;
      kick      <= 1'b0;
      product   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          arm_q   <= fi_arm;
          pers_q  <= fi_persist;
          mask_q  <= fi_mask;
          attempt <= '0;
          kick    <= 1'b1;
          state   <= PASS1;
        end
        PASS1: begin
          kick <= 1'b0;
          if (core_done) begin
            r1    <= core_res ^ (use_mask ? mask_q : '0);
            state <= (REDUNDANT != 0) ? PASS2 : CHECK;
          end
        end
        PASS2: if (core_done) begin
          r2    <= core_res;
          state <= CHECK;
        end
        CHECK: begin
          if (!mismatch) begin
            product   <= (REDUNDANT != 0) ? r2 : r1;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (can_retry) begin
              attempt <= attempt + 3'd1;
              state   <= PASS1;
            end else begin
              product   <= r2;
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mult_seq_tr.sv
// Bench for mult_seq_tr: three configurations checked every cycle against a
// transaction-level model, plus directed vectors with literal expectations.
module tb_mult_seq_tr;

  localparam int NI = 3;
  localparam int CW[NI] = '{4, 8, 4};
  localparam int CR[NI] = '{1, 1, 0};
  localparam int CM[NI] = '{1, 1, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] iv, ir, ov, er, by;
  logic ordy;
  logic [7:0] a_s, b_s;
  logic arm, pers;
  logic [15:0] fm;
  logic [7:0] p0, p2;
  logic [15:0] p1;
  logic [NI-1:0][15:0] prod_a;
  logic [NI-1:0][7:0] cnt_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq_tr #(.WIDTH(4), .REDUNDANT(1), .RETRY_MAX(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[3:0]), .b(b_s[3:0]),
    .fi_arm(arm), .fi_persist(pers), .fi_mask(fm[7:0]), .out_valid(ov[0]), .out_ready(ordy),
    .product(p0), .err(er[0]), .busy(by[0]), .err_cnt(cnt_a[0]));

  mult_seq_tr #(.WIDTH(8), .REDUNDANT(1), .RETRY_MAX(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s), .b(b_s),
    .fi_arm(arm), .fi_persist(pers), .fi_mask(fm), .out_valid(ov[1]), .out_ready(ordy),
    .product(p1), .err(er[1]), .busy(by[1]), .err_cnt(cnt_a[1]));

  mult_seq_tr #(.WIDTH(4), .REDUNDANT(0), .RETRY_MAX(1), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[3:0]), .b(b_s[3:0]),
    .fi_arm(arm), .fi_persist(pers), .fi_mask(fm[7:0]), .out_valid(ov[2]), .out_ready(ordy),
    .product(p2), .err(er[2]), .busy(by[2]), .err_cnt(cnt_a[2]));

  assign prod_a[0] = {8'd0, p0};
  assign prod_a[1] = p1;
  assign prod_a[2] = {8'd0, p2};

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Transaction model: outcome of a whole operation from the retry rules.
  function automatic void plan(input int w, input int r, input int rm, input bit fa,
                               input bit fp, input int maskv,
                               output int lat, output bit e, output int nf);
    nf = 0;
    e = 1'b0;
    lat = w + 2;
    if (r != 0) begin
      for (int t = 0; t <= rm; t++) begin
        if (maskv != 0 && (fp || (fa && t == 0))) nf++;
        else break;
      end
      e = (nf == rm + 1);
      lat = 2 * w + 2 + (e ? rm : nf) * (2 * w + 1);
    end
  endfunction

  bit pend[NI];
  bit merr[NI];
  int age[NI], mlat[NI], mcnt[NI], mprod[NI];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        pend[i] <= 1'b0;
        age[i]  <= 0;
        mcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (pend[i]) begin
          if (age[i] >= mlat[i] && ordy) pend[i] <= 1'b0;
          else age[i] <= age[i] + 1;
        end else if (iv[i]) begin
          int wm, lat, nf, nc;
          bit e;
          wm = (1 << CW[i]) - 1;
          plan(CW[i], CR[i], CM[i], arm, pers, int'(fm) & ((1 << (2 * CW[i])) - 1), lat, e, nf);
          nc = mcnt[i] + nf;
          pend[i]  <= 1'b1;
          age[i]   <= 0;
          mlat[i]  <= lat;
          merr[i]  <= e;
          mprod[i] <= (int'(a_s) & wm) * (int'(b_s) & wm);
          mcnt[i]  <= (nc > 255) ? 255 : nc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        bit ev;
        ev = pend[i] && (age[i] >= mlat[i]);
        chk("in_ready", i, int'(ir[i]), int'(!pend[i]));
        chk("busy", i, int'(by[i]), int'(pend[i]));
        chk("out_valid", i, int'(ov[i]), int'(ev));
        if (ev) begin
          chk("product", i, int'(prod_a[i]), mprod[i]);
          chk("err", i, int'(er[i]), int'(merr[i]));
          chk("err_cnt", i, int'(cnt_a[i]), mcnt[i]);
        end
      end
    end
  end

  task automatic run_op(input int i, input logic [7:0] xa, input logic [7:0] xb,
                        input bit fa, input bit fp, input logic [15:0] mk, input int hold,
                        output int n, output int p, output int e, output int c);
    @(negedge clk);
    a_s = xa; b_s = xb; arm = fa; pers = fp; fm = mk;
    iv[i] = 1'b1;
    ordy = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    if (hold == 0) iv[i] = 1'b0;
    // operand and fault inputs change while busy and must be ignored
    a_s = ~xa; b_s = ~xb; arm = ~fa; pers = ~fp; fm = ~mk;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (ov[i]) break;
    end
    chk("out_valid_seen", i, int'(ov[i]), 1);
    p = int'(prod_a[i]);
    e = int'(er[i]);
    c = int'(cnt_a[i]);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      ordy = 1'b1;
      iv[i] = 1'b0;
    end
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, e, c;
    rst_n = 1'b0;
    iv = '0; ordy = 1'b1;
    a_s = '0; b_s = '0; arm = 1'b0; pers = 1'b0; fm = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", i, int'(ov[i]), 0);
      chk("rst_product", i, int'(prod_a[i]), 0);
      chk("rst_err", i, int'(er[i]), 0);
      chk("rst_err_cnt", i, int'(cnt_a[i]), 0);
      chk("rst_busy", i, int'(by[i]), 0);
      chk("rst_in_ready", i, int'(ir[i]), 1);
    end

    run_op(0, 8'd15, 8'd15, 1'b0, 1'b0, 16'h0, 0, n, p, e, c);
    chk("lat_15x15", 0, n, 10); chk("prod_15x15", 0, p, 225);
    chk("err_15x15", 0, e, 0);  chk("cnt_15x15", 0, c, 0);

    run_op(0, 8'd0, 8'd7, 1'b0, 1'b0, 16'h0, 3, n, p, e, c);
    chk("lat_0x7", 0, n, 10); chk("prod_0x7", 0, p, 0);

    run_op(0, 8'd13, 8'd11, 1'b1, 1'b0, 16'h01, 0, n, p, e, c);
    chk("lat_arm", 0, n, 19); chk("prod_arm", 0, p, 143);
    chk("err_arm", 0, e, 0);  chk("cnt_arm", 0, c, 1);

    // reset in the middle of pass 2 discards the operation
    @(negedge clk);
    a_s = 8'd13; b_s = 8'd11; arm = 1'b0; pers = 1'b0; fm = '0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 0, int'(ov[0]), 0);
    chk("midrst_busy", 0, int'(by[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 8'd3, 8'd5, 1'b0, 1'b0, 16'h0, 0, n, p, e, c);
    chk("lat_3x5", 0, n, 10); chk("prod_3x5", 0, p, 15);
    chk("err_3x5", 0, e, 0);  chk("cnt_3x5", 0, c, 0);

    run_op(0, 8'd13, 8'd11, 1'b0, 1'b1, 16'h80, 0, n, p, e, c);
    chk("lat_persist", 0, n, 19); chk("prod_persist", 0, p, 143);
    chk("err_persist", 0, e, 1);  chk("cnt_persist", 0, c, 2);

    run_op(2, 8'd15, 8'd15, 1'b0, 1'b0, 16'h0, 0, n, p, e, c);
    chk("lat_r0", 2, n, 6); chk("prod_r0", 2, p, 225); chk("err_r0", 2, e, 0);

    run_op(1, 8'd255, 8'd255, 1'b0, 1'b0, 16'h0, 0, n, p, e, c);
    chk("lat_w8max", 1, n, 18); chk("prod_w8max", 1, p, 65025); chk("err_w8max", 1, e, 0);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(0, 8'(x), 8'(y), 1'b0, 1'b0, 16'h0, 0, n, p, e, c);
        chk("sweep_lat", 0, n, 10);
        run_op(2, 8'(x), 8'(y), 1'b0, 1'b0, 16'h0, 0, n, p, e, c);
        chk("sweep_lat", 2, n, 6);
      end
    end
    for (int k = 0; k < 256; k++) begin
      run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'b0, 1'b0, 16'h0, 0, n, p, e, c);
      chk("sweep_lat", 1, n, 18);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_tr.md
Name: mult_seq_tr

Overview:
- Parametrised unsigned WIDTH x WIDTH multiplier. Successor to the fixed 4-bit combinational fault-resilient multiplier family.
- Iterative shift-add datapath with time redundancy: each product is computed twice, the second time with operands swapped, and the two results are compared.
- On mismatch the block retries up to RETRY_MAX times, then flags an error.
- Sits behind a valid/ready handshake as the arithmetic unit for fault-resilience evaluation builds.

Parameters:
- WIDTH, 4: operand width; product width is 2*WIDTH; WIDTH >= 2.
- REDUNDANT, 1: 1 = dual-pass compare; 0 = single pass, no compare, err is tied to 0.
- RETRY_MAX, 1: extra full attempts (pass 1 + pass 2) after a mismatch; range 0..7.
- CNT_W, 8: width of the saturating mismatch counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- fi_arm  in  1  test hook: sampled at accept; XORs fi_mask into the pass-1 result of the first attempt.
- fi_persist  in  1  sampled at accept; applies the mask to the pass-1 result of every attempt.
- fi_mask  in  2*WIDTH  fault pattern, sampled at accept.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer ready.
- product  out  2*WIDTH  a*b (the pass-2 result when REDUNDANT=1).
- err  out  1  all attempts mismatched; qualified by out_valid.
- busy  out  1  state != IDLE.
- err_cnt  out  CNT_W  saturating count of mismatching compares since reset.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - out_valid=0, product=0, err=0, err_cnt=0, busy=0, in_ready=1.
  - All internal registers and fi latches are cleared.
  - Reset mid-operation discards the operation; no output is produced.
- States: IDLE, PASS1, PASS2, CHECK, OUT.
- IDLE:
  - in_valid and in_ready both high at edge k means accept.
  - Latch a, b, fi_* and set attempt counter = 0.
  - Go to PASS1.
- PASS1: WIDTH cycles (k+1..k+WIDTH).
  - acc starts at 0; each cycle, if mreg[0] then acc += mcand << i; mreg >>= 1.
  - The add uses a 2*WIDTH-bit wide adder; no overflow is possible.
  - End of pass: r1 = acc ^ (mask when (fi_arm and attempt==0) or fi_persist, else 0).
- PASS2 (REDUNDANT=1 only): same WIDTH-cycle procedure with mcand=b, mreg=a; the result is r2.
- CHECK: 1 cycle.
  - r1==r2: product=r2, err=0, go to OUT.
  - Mismatch: increment err_cnt (saturates at all-ones).
    - attempt < RETRY_MAX: increment attempt, go to PASS1.
    - attempt == RETRY_MAX: product=r2, err=1, go to OUT.
- REDUNDANT=0: PASS1 then CHECK; CHECK always passes with product=r1.
- OUT:
  - out_valid=1; product and err stay stable until out_ready is high at an edge.
  - At that edge: out_valid goes to 0 and state goes to IDLE.
  - in_ready is low throughout OUT, so in_valid during OUT is ignored (no back-to-back overlap).
- Latency from accept edge k to the first out_valid cycle:
  - REDUNDANT=1: k + 2*WIDTH + 2.
  - REDUNDANT=0: k + WIDTH + 2.
  - Each retry adds 2*WIDTH + 1 cycles.
- Boundary cases:
  - a=0 or b=0 still runs the full pass length; no early exit, so latency is deterministic.
  - Maximum operands give (2^W - 1)^2 with no truncation.
  - Operands and fi_* changing while busy have no effect.

Decomposition:
- Package mult_tr_pkg:
  - state enum (IDLE, PASS1, PASS2, CHECK, OUT).
  - functions lat_cycles(WIDTH, REDUNDANT) and retry_cycles(WIDTH).
  - localparam PW = 2*WIDTH.
- Sub-module mult_shift_add_core: one pass engine.
  - Inputs: start, mcand, mplier.
  - Outputs: done pulse, result.
  - Reused for both passes; the FSM swaps the operands it feeds in.

Test Plan:
- WIDTH=4, REDUNDANT=1: a=15, b=15 accepted at edge k -> out_valid at k+10, product=225, err=0, err_cnt=0.
- a=0, b=7 -> product=0 at k+10; out_ready held low 3 cycles -> product/out_valid stable, in_ready=0 while in_valid stays high.
- a=13, b=11, fi_arm=1, fi_mask=8'h01, RETRY_MAX=1 -> one mismatch, retry passes; out_valid at k+19, product=143, err=0, err_cnt=1.
- a=13, b=11, fi_persist=1, fi_mask=8'h80, RETRY_MAX=1 -> two mismatches; out_valid at k+19, product=143, err=1, err_cnt=2.
- rst_n pulsed low during PASS2 -> out_valid=0 immediately, busy=0; next op a=3, b=5 -> product=15, no stale output.
- Randomised sweep of all 256 pairs, WIDTH=4 and WIDTH=8 (REDUNDANT 0/1) -> product==a*b, err=0, latency matches lat_cycles.
